// File: rtl/sipo_pkg.sv
// sipo_pkg: shared bit-order constants, reset value and counter-width helper for the SIPO deserialiser
package sipo_pkg;
  localparam bit SIPO_MSB_FIRST = 1'b1;
  localparam bit SIPO_LSB_FIRST = 1'b0;
  localparam logic SIPO_RST_BIT = 1'b0;
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/sipo_out_slot.sv
// sipo_out_slot: one-entry valid/ready word slot (clk, rst active-low sync, word/word_done/q_ready/clr_ovf in; q/q_valid/overflow out)
module sipo_out_slot
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word,
  input  logic             word_done,
  input  logic             q_ready,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             overflow
);
  logic [WIDTH-1:0] q_q, q_d;
  logic v_q, v_d, ovf_q, ovf_d, wr, drop;
  always_comb begin
    wr    = word_done && (!v_q || q_ready);
    drop  = word_done && !wr;
    q_d   = wr ? word : q_q;
    v_d   = wr || (v_q && !q_ready);
    ovf_d = drop || (ovf_q && !clr_ovf);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q   <= {WIDTH{SIPO_RST_BIT}};
      v_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      v_q   <= v_d;
      ovf_q <= ovf_d;
    end
  end
  assign q        = q_q;
  assign q_valid  = v_q;
  assign overflow = ovf_q;
endmodule

// File: rtl/sipo_stream.sv
// sipo_stream: serial-in/parallel-out deserialiser (clk, rst active-low sync, d/d_valid/sof/q_ready/clr_ovf in; q/q_valid/shift_q/bit_cnt/overflow out)
module sipo_stream
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = SIPO_MSB_FIRST,
  localparam int CNT_W    = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             d_valid,
  input  logic             sof,
  input  logic             q_ready,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [WIDTH-1:0] shift_q,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overflow
);
  logic [WIDTH-1:0] sr_q, sr_d, base;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic done;
  always_comb begin
    base  = sof ? {WIDTH{SIPO_RST_BIT}} : sr_q;
    sr_d  = d_valid ? (MSB_FIRST ? {base[WIDTH-2:0], d} : {d, base[WIDTH-1:1]}) : sr_q;
    done  = d_valid && !sof && cnt_q == CNT_W'(WIDTH - 1);
    cnt_d = !d_valid ? cnt_q : sof ? CNT_W'(1) : done ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q  <= {WIDTH{SIPO_RST_BIT}};
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end
  assign shift_q = sr_q;
  assign bit_cnt = cnt_q;
  sipo_out_slot #(.WIDTH(WIDTH)) u_slot (
    .clk      (clk),
    .rst      (rst),
    .word     (sr_d),
    .word_done(done),
    .q_ready  (q_ready),
    .clr_ovf  (clr_ovf),
    .q        (q),
    .q_valid  (q_valid),
    .overflow (overflow)
  );
endmodule

// File: tb/tb_sipo_stream.sv
// tb_sipo_stream: directed and randomized checks of MSB- and LSB-first deserialisers against a bit-history model
module tb_sipo_stream;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d = 1'b0, d_valid = 1'b0, sof = 1'b0, q_ready = 1'b1, clr_ovf = 1'b0;
  logic [W-1:0] qm, sm, ql, sl;
  logic [2:0] cm, cl;
  logic qvm, om, qvl, ol;
  int errors = 0;
  int checks = 0;
  bit hist[$];
  int fb = 0;
  logic [W-1:0] mq_m = '0, mq_l = '0;
  logic mv = 1'b0, mo = 1'b0;
  always #5 clk = ~clk;
  sipo_stream #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .sof(sof), .q_ready(q_ready), .clr_ovf(clr_ovf),
    .q(qm), .q_valid(qvm), .shift_q(sm), .bit_cnt(cm), .overflow(om));
  sipo_stream #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .sof(sof), .q_ready(q_ready), .clr_ovf(clr_ovf),
    .q(ql), .q_valid(qvl), .shift_q(sl), .bit_cnt(cl), .overflow(ol));
  function automatic logic [W-1:0] pack_msb();
    logic [W-1:0] v = '0;
    for (int i = 0; i < hist.size(); i++) v = {v[W-2:0], 1'(hist[i])};
    return v;
  endfunction
  function automatic logic [W-1:0] pack_lsb();
    logic [W-1:0] v = '0;
    for (int i = 0; i < hist.size(); i++) v[W - hist.size() + i] = hist[i];
    return v;
  endfunction
  task automatic step(input logic id, input logic idv, input logic isof, input logic iqr, input logic iclr);
    bit done, set;
    d = id; d_valid = idv; sof = isof; q_ready = iqr; clr_ovf = iclr;
    @(posedge clk);
    if (!rst) begin
      hist.delete(); fb = 0; mq_m = '0; mq_l = '0; mv = 1'b0; mo = 1'b0;
    end else begin
      done = 1'b0;
      if (idv) begin
        if (isof) begin hist.delete(); fb = 0; end
        hist.push_back(id);
        if (hist.size() > W) void'(hist.pop_front());
        fb++;
        done = (fb % W == 0);
      end
      set = done && mv && !iqr;
      if (done && (!mv || iqr)) begin mq_m = pack_msb(); mq_l = pack_lsb(); mv = 1'b1; end
      else if (!done && mv && iqr) mv = 1'b0;
      mo = set ? 1'b1 : (iclr ? 1'b0 : mo);
    end
    #1;
  endtask
  task automatic send_msb(input logic [W-1:0] w, input logic iqr);
    for (int i = W - 1; i >= 0; i--) step(w[i], 1'b1, 1'b0, iqr, 1'b0);
  endtask
  task automatic test_reset();
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    checks++; if ({qm, qvm, sm, cm, om} !== '0) begin errors++; $display("FAIL reset_m: got q=%h v=%b s=%h c=%0d o=%b want all 0", qm, qvm, sm, cm, om); end
    checks++; if ({ql, qvl, sl, cl, ol} !== '0) begin errors++; $display("FAIL reset_l: got q=%h v=%b s=%h c=%0d o=%b want all 0", ql, qvl, sl, cl, ol); end
  endtask
  task automatic test_msb();
    send_msb(8'hA5, 1'b1);
    checks++; if (qm !== 8'hA5 || qvm !== 1'b1) begin errors++; $display("FAIL msb_word: got q=%h v=%b want A5 1", qm, qvm); end
    checks++; if (cm !== 3'd0) begin errors++; $display("FAIL msb_cnt: got %0d want 0", cm); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (qvm !== 1'b0) begin errors++; $display("FAIL msb_drain: got v=%b want 0", qvm); end
  endtask
  task automatic test_lsb();
    logic [W-1:0] w = 8'hA5;
    for (int i = 0; i < W; i++) step(w[i], 1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (ql !== 8'hA5 || qvl !== 1'b1) begin errors++; $display("FAIL lsb_word: got q=%h v=%b want A5 1", ql, qvl); end
    checks++; if (sl !== 8'hA5) begin errors++; $display("FAIL lsb_shift: got %h want A5", sl); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic test_gaps();
    logic [W-1:0] w = 8'h3C;
    for (int i = 0; i < W; i++) begin
      step(w[W-1-i], 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'($urandom), 1'b0, 1'($urandom), 1'b1, 1'b0);
      checks++; if (cm !== 3'((i + 1) % W)) begin errors++; $display("FAIL gap_cnt%0d: got %0d want %0d", i, cm, (i + 1) % W); end
    end
    checks++; if (qm !== 8'h3C) begin errors++; $display("FAIL gap_word: got %h want 3C", qm); end
  endtask
  task automatic test_overflow();
    send_msb(8'h3C, 1'b0);
    checks++; if (qm !== 8'h3C || qvm !== 1'b1 || om !== 1'b0) begin errors++; $display("FAIL ovf_first: got q=%h v=%b o=%b want 3C 1 0", qm, qvm, om); end
    send_msb(8'hC3, 1'b0);
    checks++; if (qm !== 8'h3C || om !== 1'b1) begin errors++; $display("FAIL ovf_hold: got q=%h o=%b want 3C 1", qm, om); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (qvm !== 1'b0 || om !== 1'b1) begin errors++; $display("FAIL ovf_drain: got v=%b o=%b want 0 1", qvm, om); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (om !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", om); end
  endtask
  task automatic test_sof();
    logic [W-1:0] w = 8'hB1;
    for (int i = 0; i < 3; i++) step(1'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
    step(w[W-1], 1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (cm !== 3'd1 || sm !== 8'h01) begin errors++; $display("FAIL sof_cnt: got c=%0d s=%h want 1 01", cm, sm); end
    for (int i = W - 2; i >= 0; i--) step(w[i], 1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (qm !== 8'hB1 || qvm !== 1'b1) begin errors++; $display("FAIL sof_word: got q=%h v=%b want B1 1", qm, qvm); end
  endtask
  task automatic test_rst_mid();
    send_msb(8'h5A, 1'b0);
    send_msb(8'h11, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; #3; rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (qvm !== 1'b1 || cm !== 3'd3 || om !== 1'b1 || sm !== 8'h8F) begin errors++; $display("FAIL glitch_rst: got v=%b c=%0d o=%b s=%h want 1 3 1 8F", qvm, cm, om, sm); end
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    checks++; if ({qm, qvm, sm, cm, om} !== '0 || {ql, qvl, sl, cl, ol} !== '0) begin errors++; $display("FAIL mid_rst: got q=%h v=%b s=%h c=%0d o=%b want all 0", qm, qvm, sm, cm, om); end
  endtask
  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) != 0);
      step(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
      checks++;
      if (qm !== mq_m || ql !== mq_l || qvm !== mv || qvl !== mv || om !== mo || ol !== mo ||
          sm !== pack_msb() || sl !== pack_lsb() || cm !== 3'(fb % W) || cl !== 3'(fb % W)) begin
        errors++;
        $display("FAIL rand%0d: got qm=%h ql=%h v=%b o=%b sm=%h sl=%h c=%0d want %h %h %b %b %h %h %0d",
                 n, qm, ql, qvm, om, sm, sl, cm, mq_m, mq_l, mv, mo, pack_msb(), pack_lsb(), fb % W);
      end
    end
    rst = 1'b1;
  endtask
  initial begin
    test_reset();
    test_msb();
    test_lsb();
    test_gaps();
    test_overflow();
    test_sof();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
